// File: rtl/mult_m_stage.sv
// Signed 25x18 radix-4 Booth multiplier producing two 43-bit partial-product sums,
// with an optional M pipeline register selected by static configuration.
module mult_m_stage (
    input  logic        clk,
    input  logic        RSTM,
    input  logic        CEM,
    input  logic [24:0] a_mult,
    input  logic [17:0] b_mult,
    input  logic        sel_M_p,
    input  logic        use_mult_p,
    output logic [42:0] out_pp1,
    output logic [42:0] out_pp2
);

    localparam int unsigned A_W     = 25;
    localparam int unsigned B_W     = 18;
    localparam int unsigned P_W     = 43;
    localparam int unsigned N_ROWS  = 9;

    typedef struct packed {
        logic [P_W-1:0] s;
        logic [P_W-1:0] c;
    } csa_t;

    // 3:2 carry-save compressor; the carry out of the top bit is dropped (mod 2^43).
    function automatic csa_t csa(input logic [P_W-1:0] x,
                                 input logic [P_W-1:0] y,
                                 input logic [P_W-1:0] z);
        csa_t r;
        r.s = x ^ y ^ z;
        r.c = {(x[P_W-2:0] & y[P_W-2:0]) |
               (x[P_W-2:0] & z[P_W-2:0]) |
               (y[P_W-2:0] & z[P_W-2:0]), 1'b0};
        return r;
    endfunction

    logic [B_W:0]   b_ext;
    logic [P_W-1:0] a_sx;
    logic [P_W-1:0] a_x2;
    logic [P_W-1:0] row [N_ROWS];
    logic [N_ROWS-1:0] neg_v;
    logic [P_W-1:0] corr1;
    logic [P_W-1:0] corr2;

    assign b_ext = {b_mult, 1'b0};
    assign a_sx  = {{(P_W-A_W){a_mult[A_W-1]}}, a_mult};
    assign a_x2  = {{(P_W-A_W-1){a_mult[A_W-1]}}, a_mult, 1'b0};

    // Booth row generation: select 0/a/2a, conditionally invert, align to 4^i.
    for (genvar g = 0; g < N_ROWS; g++) begin : g_row
        logic [2:0]     trip;
        logic           one;
        logic           two;
        logic [P_W-1:0] mag;

        assign trip     = b_ext[2*g+2 -: 3];
        assign one      = trip[1] ^ trip[0];
        assign two      = (trip == 3'b011) || (trip == 3'b100);
        assign neg_v[g] = trip[2];
        assign mag      = one ? a_sx : (two ? a_x2 : '0);
        assign row[g]   = (mag ^ {P_W{trip[2]}}) << (2*g);
    end

    // Two's-complement correction bits land on distinct positions, so they pack into one vector.
    assign corr1 = {33'd0, neg_v[4], 1'b0, neg_v[3], 1'b0, neg_v[2],
                    1'b0, neg_v[1], 1'b0, neg_v[0]};
    assign corr2 = {26'd0, neg_v[8], 1'b0, neg_v[7], 1'b0, neg_v[6],
                    1'b0, neg_v[5], 10'd0};

    csa_t g1_l1a, g1_l1b, g1_l2, g1_l3;
    csa_t g2_l1, g2_l2, g2_l3;
    logic [P_W-1:0] sum1;
    logic [P_W-1:0] sum2;
    logic [P_W-1:0] pp1_c;
    logic [P_W-1:0] pp2_c;

    // Group 1: rows 0..4 plus corrections, 6 -> 2 operands then a carry-propagate add.
    always_comb begin
        g1_l1a = csa(row[0], row[1], row[2]);
        g1_l1b = csa(row[3], row[4], corr1);
        g1_l2  = csa(g1_l1a.s, g1_l1a.c, g1_l1b.s);
        g1_l3  = csa(g1_l2.s, g1_l2.c, g1_l1b.c);
        sum1   = g1_l3.s + g1_l3.c;
    end

    // Group 2: rows 5..8 plus corrections, 5 -> 2 operands then a carry-propagate add.
    always_comb begin
        g2_l1 = csa(row[5], row[6], row[7]);
        g2_l2 = csa(g2_l1.s, g2_l1.c, row[8]);
        g2_l3 = csa(g2_l2.s, g2_l2.c, corr2);
        sum2  = g2_l3.s + g2_l3.c;
    end

    // Disable gating sits ahead of the M register so a disabled multiplier loads zeros.
    always_comb begin
        pp1_c = '0;
        pp2_c = '0;
        if (use_mult_p) begin
            pp1_c = sum1;
            pp2_c = sum2;
        end
    end

    logic [P_W-1:0] m_pp1;
    logic [P_W-1:0] m_pp2;

    always_ff @(posedge clk) begin
        if (RSTM) begin
            m_pp1 <= '0;
            m_pp2 <= '0;
        end else if (CEM) begin
            m_pp1 <= pp1_c;
            m_pp2 <= pp2_c;
        end
    end

    assign out_pp1 = sel_M_p ? m_pp1 : pp1_c;
    assign out_pp2 = sel_M_p ? m_pp2 : pp2_c;

endmodule

// File: tb/tb_mult_m_stage.sv
// Randomized self-checking bench for mult_m_stage against an arithmetic Booth-digit model.
module tb_mult_m_stage;

    logic        clk;
    logic        RSTM;
    logic        CEM;
    logic [24:0] a_mult;
    logic [17:0] b_mult;
    logic        sel_M_p;
    logic        use_mult_p;
    logic [42:0] out_pp1;
    logic [42:0] out_pp2;

    mult_m_stage dut (
        .clk        (clk),
        .RSTM       (RSTM),
        .CEM        (CEM),
        .a_mult     (a_mult),
        .b_mult     (b_mult),
        .sel_M_p    (sel_M_p),
        .use_mult_p (use_mult_p),
        .out_pp1    (out_pp1),
        .out_pp2    (out_pp2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected M register contents and the product it represents.
    logic [42:0] m1 = '0;
    logic [42:0] m2 = '0;
    logic [42:0] mprod = '0;

    task automatic check(input string tag, input logic [42:0] got, input logic [42:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Row-group sums from the Booth digit definition using plain integer arithmetic.
    function automatic void ref_pp(input logic [24:0] a, input logic [17:0] b, input logic use_m,
                                   output logic [42:0] p1, output logic [42:0] p2);
        longint sa, d, acc1, acc2;
        logic [18:0] bb;
        sa   = longint'($signed(a));
        bb   = {b, 1'b0};
        acc1 = 0;
        acc2 = 0;
        for (int i = 0; i < 9; i++) begin
            d = -2 * longint'(bb[2*i+2]) + longint'(bb[2*i+1]) + longint'(bb[2*i]);
            if (i < 5) acc1 += d * sa * (longint'(1) << (2*i));
            else       acc2 += d * sa * (longint'(1) << (2*i));
        end
        p1 = use_m ? 43'(acc1) : 43'd0;
        p2 = use_m ? 43'(acc2) : 43'd0;
    endfunction

    function automatic logic [42:0] ref_prod(input logic [24:0] a, input logic [17:0] b,
                                             input logic use_m);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return use_m ? 43'(p) : 43'd0;
    endfunction

    task automatic cycle(input logic [24:0] a, input logic [17:0] b, input logic cem,
                         input logic rst, input logic sel, input logic use_m);
        logic [42:0] c1, c2, cp, s;
        @(negedge clk);
        a_mult     = a;
        b_mult     = b;
        CEM        = cem;
        RSTM       = rst;
        sel_M_p    = sel;
        use_mult_p = use_m;
        ref_pp(a, b, use_m, c1, c2);
        cp = ref_prod(a, b, use_m);
        #1;
        if (!sel) begin
            check("comb_pp1", out_pp1, c1);
            check("comb_pp2", out_pp2, c2);
        end
        @(posedge clk);
        if (rst) begin
            m1 = '0; m2 = '0; mprod = '0;
        end else if (cem) begin
            m1 = c1; m2 = c2; mprod = cp;
        end
        #1;
        s = out_pp1 + out_pp2;
        check("pp1", out_pp1, sel ? m1 : c1);
        check("pp2", out_pp2, sel ? m2 : c2);
        check("sum", s, sel ? mprod : cp);
    endtask

    logic [42:0] tot;
    logic [24:0] ra;
    logic [17:0] rb;
    logic [24:0] a_edge [4];
    logic [17:0] b_edge [4];

    initial begin
        RSTM = 1'b1; CEM = 1'b0; a_mult = '0; b_mult = '0;
        sel_M_p = 1'b1; use_mult_p = 1'b1;
        a_edge = '{25'h1000000, 25'h0FFFFFF, 25'h1FFFFFF, 25'h0000001};
        b_edge = '{18'h20000, 18'h1FFFF, 18'h3FFFF, 18'h2AAAA};

        cycle(25'd0, 18'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_pp1", out_pp1, 43'd0);
        check("reset_pp2", out_pp2, 43'd0);

        cycle(25'd3, 18'd5, 1'b1, 1'b0, 1'b1, 1'b1);
        check("a3b5_pp1", out_pp1, 43'd15);
        check("a3b5_pp2", out_pp2, 43'd0);

        cycle(25'd1, 18'h20000, 1'b1, 1'b0, 1'b1, 1'b1);
        check("bmin_pp1", out_pp1, 43'd0);
        check("bmin_pp2", out_pp2, 43'h7FFFFFE0000);

        cycle(25'h1000000, 18'h20000, 1'b1, 1'b0, 1'b1, 1'b1);
        check("minmin_pp1", out_pp1, 43'd0);
        check("minmin_pp2", out_pp2, 43'h20000000000);
        cycle(25'h1000000, 18'h20000, 1'b1, 1'b0, 1'b0, 1'b1);
        check("minmin_byp_pp2", out_pp2, 43'h20000000000);

        cycle(25'd7, 18'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        tot = out_pp1 + out_pp2;
        check("hold_load", tot, 43'd63);
        for (int k = 0; k < 3; k++) begin
            cycle(25'd2, 18'd2, 1'b0, 1'b0, 1'b1, 1'b1);
            tot = out_pp1 + out_pp2;
            check("hold_keep", tot, 43'd63);
        end
        cycle(25'd2, 18'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        tot = out_pp1 + out_pp2;
        check("hold_release", tot, 43'd4);

        cycle(25'd100, 18'd100, 1'b1, 1'b1, 1'b1, 1'b1);
        check("rst_wins_pp1", out_pp1, 43'd0);
        check("rst_wins_pp2", out_pp2, 43'd0);
        cycle(25'd100, 18'd100, 1'b1, 1'b0, 1'b1, 1'b1);
        tot = out_pp1 + out_pp2;
        check("after_rst", tot, 43'd10000);
        cycle(25'd100, 18'd100, 1'b1, 1'b0, 1'b1, 1'b0);
        check("nouse_pp1", out_pp1, 43'd0);
        check("nouse_pp2", out_pp2, 43'd0);
        cycle(25'd100, 18'd100, 1'b1, 1'b1, 1'b0, 1'b1);
        tot = out_pp1 + out_pp2;
        check("byp_ignores_rst", tot, 43'd10000);

        for (int i = 0; i < 10000; i++) begin
            ra = 25'($urandom);
            rb = 18'($urandom);
            if ($urandom_range(0, 7) == 0) ra = a_edge[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) rb = b_edge[$urandom_range(0, 3)];
            cycle(ra, rb,
                  $urandom_range(0, 7) != 0,
                  $urandom_range(0, 31) == 0,
                  1'(i % 2),
                  $urandom_range(0, 15) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
